// File: rtl/dual_issue_ctrl_pkg.sv
// Shared definitions for the dual-issue scheduler: register index width, FSM states and
// the decode-class flag bundle.
package dual_issue_ctrl_pkg;

   localparam int unsigned REG_AW_DEF = 5;
   localparam int unsigned CLASS_W    = 4;
   localparam int unsigned CNT_W      = 3;

   typedef enum logic [1:0] {
      StRun        = 2'd0,
      StSerialWait = 2'd1,
      StFlushBub   = 2'd2
   } state_e;

   typedef struct packed {
      logic is_load;
      logic is_branch;
      logic is_muldiv;
      logic is_serial;
   } cls_t;

endpackage

// File: rtl/dual_pair_hazard.sv
// Combinational hazard check for the queue-head pair: intra-pair block (RAW, WAW, branch,
// serial, muldiv) and load-use matches of each line against the load tracker.
module dual_pair_hazard
   import dual_issue_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] rd1_i,
   input  logic              rd1_we_i,
   input  logic [REG_AW-1:0] rd2_i,
   input  logic              rd2_we_i,
   input  logic [REG_AW-1:0] l1_rs1_i,
   input  logic              l1_rs1_use_i,
   input  logic [REG_AW-1:0] l1_rs2_i,
   input  logic              l1_rs2_use_i,
   input  logic [REG_AW-1:0] l2_rs1_i,
   input  logic              l2_rs1_use_i,
   input  logic [REG_AW-1:0] l2_rs2_i,
   input  logic              l2_rs2_use_i,
   input  cls_t              cls1_i,
   input  cls_t              cls2_i,
   input  logic [REG_AW-1:0] ld0_i,
   input  logic [REG_AW-1:0] ld1_i,
   output logic              pair_block_o,
   output logic              lu1_o,
   output logic              lu2_o
);

   // Register 0 is hardwired, so a zero target never matches.
   function automatic logic hit(logic [REG_AW-1:0] rs, logic en, logic [REG_AW-1:0] rd);
      return en && (rd != '0) && (rs == rd);
   endfunction

   logic raw, waw;
   logic unused_cls;

   assign lu1_o = hit(l1_rs1_i, l1_rs1_use_i, ld0_i) | hit(l1_rs1_i, l1_rs1_use_i, ld1_i) |
                  hit(l1_rs2_i, l1_rs2_use_i, ld0_i) | hit(l1_rs2_i, l1_rs2_use_i, ld1_i);
   assign lu2_o = hit(l2_rs1_i, l2_rs1_use_i, ld0_i) | hit(l2_rs1_i, l2_rs1_use_i, ld1_i) |
                  hit(l2_rs2_i, l2_rs2_use_i, ld0_i) | hit(l2_rs2_i, l2_rs2_use_i, ld1_i);

   assign raw = rd1_we_i & (hit(l2_rs1_i, l2_rs1_use_i, rd1_i) |
                            hit(l2_rs2_i, l2_rs2_use_i, rd1_i));
   assign waw = rd1_we_i & rd2_we_i & (rd1_i != '0) & (rd1_i == rd2_i);

   assign pair_block_o = raw | waw | cls1_i.is_branch | cls1_i.is_serial | cls2_i.is_serial |
                         (cls1_i.is_muldiv & cls2_i.is_muldiv);

   assign unused_cls = ^{cls1_i.is_load, cls2_i.is_load, cls2_i.is_branch};

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue scheduler between the IF/ID queue and ID->EXE. Optional performance
// counters are enabled with the ISSUE_PERF_CNT_EN macro.
module dual_issue_ctrl
   import dual_issue_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW        = REG_AW_DEF,
   parameter int unsigned FLUSH_BUBBLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line1_valid_i,
   input  logic              line2_valid_i,
   input  logic              next_allowin_i,
   input  logic [REG_AW-1:0] line1_rd_i,
   input  logic              line1_rd_we_i,
   input  logic [REG_AW-1:0] line1_rs1_i,
   input  logic [REG_AW-1:0] line1_rs2_i,
   input  logic              line1_rs1_use_i,
   input  logic              line1_rs2_use_i,
   input  logic              line1_is_load_i,
   input  logic              line1_is_branch_i,
   input  logic              line1_is_muldiv_i,
   input  logic              line1_is_serial_i,
   input  logic [REG_AW-1:0] line2_rd_i,
   input  logic              line2_rd_we_i,
   input  logic [REG_AW-1:0] line2_rs1_i,
   input  logic [REG_AW-1:0] line2_rs2_i,
   input  logic              line2_rs1_use_i,
   input  logic              line2_rs2_use_i,
   input  logic              line2_is_load_i,
   input  logic              line2_is_branch_i,
   input  logic              line2_is_muldiv_i,
   input  logic              line2_is_serial_i,
   input  logic              serial_done_i,
   input  logic              branch_flush_i,
   input  logic              excep_flush_i,
   output logic              queue_allowin_o,
   output logic              lunch_stall_o,
   output logic              issue1_o,
   output logic              issue2_o,
   output logic [1:0]        state_o
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [31:0]       perf_dual_o,
   output logic [31:0]       perf_single_o,
   output logic [31:0]       perf_stall_o
`endif
);

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [REG_AW-1:0] ld0_q, ld1_q;
   logic              flush, run, lu1, lu2, pair_block, can1, can2;
   cls_t              cls1, cls2;

   assign cls1 = '{is_load: line1_is_load_i, is_branch: line1_is_branch_i,
                   is_muldiv: line1_is_muldiv_i, is_serial: line1_is_serial_i};
   assign cls2 = '{is_load: line2_is_load_i, is_branch: line2_is_branch_i,
                   is_muldiv: line2_is_muldiv_i, is_serial: line2_is_serial_i};

   dual_pair_hazard #(
      .REG_AW(REG_AW)
   ) u_hazard (
      .rd1_i        (line1_rd_i),
      .rd1_we_i     (line1_rd_we_i),
      .rd2_i        (line2_rd_i),
      .rd2_we_i     (line2_rd_we_i),
      .l1_rs1_i     (line1_rs1_i),
      .l1_rs1_use_i (line1_rs1_use_i),
      .l1_rs2_i     (line1_rs2_i),
      .l1_rs2_use_i (line1_rs2_use_i),
      .l2_rs1_i     (line2_rs1_i),
      .l2_rs1_use_i (line2_rs1_use_i),
      .l2_rs2_i     (line2_rs2_i),
      .l2_rs2_use_i (line2_rs2_use_i),
      .cls1_i       (cls1),
      .cls2_i       (cls2),
      .ld0_i        (ld0_q),
      .ld1_i        (ld1_q),
      .pair_block_o (pair_block),
      .lu1_o        (lu1),
      .lu2_o        (lu2)
   );

   assign flush = branch_flush_i | excep_flush_i;
   assign run   = (state_q == StRun);
   assign can1  = run & line1_valid_i & next_allowin_i & ~flush & ~lu1;
   assign can2  = can1 & line2_valid_i & ~lu2 & ~pair_block;

   // Gated by rst_n so nothing pops while reset is held, even with valid lines at the head.
   assign issue1_o        = rst_n & can1;
   assign issue2_o        = rst_n & can2;
   assign queue_allowin_o = rst_n & can1 & (can2 | ~line2_valid_i);
   assign lunch_stall_o   = rst_n & can1 & line2_valid_i & ~can2;
   assign state_o         = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         cnt_q   <= '0;
         ld0_q   <= '0;
         ld1_q   <= '0;
      end else if (flush) begin
         state_q <= (FLUSH_BUBBLES == 0) ? StRun : StFlushBub;
         cnt_q   <= CNT_W'(FLUSH_BUBBLES);
         ld0_q   <= '0;
         ld1_q   <= '0;
      end else begin
         unique case (state_q)
            StRun:        if (can1 && line1_is_serial_i) state_q <= StSerialWait;
            StSerialWait: if (serial_done_i) state_q <= StRun;
            StFlushBub: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= StRun;
            end
            default:      state_q <= StRun;
         endcase
         // Tracker holds while stalled so the bubble lasts until downstream accepts.
         if (next_allowin_i) begin
            ld0_q <= (can1 && line1_is_load_i && line1_rd_we_i) ? line1_rd_i : '0;
            ld1_q <= (can2 && line2_is_load_i && line2_rd_we_i) ? line2_rd_i : '0;
         end
      end
   end

`ifdef ISSUE_PERF_CNT_EN
   logic [31:0] perf_dual_q, perf_single_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_dual_q   <= '0;
         perf_single_q <= '0;
         perf_stall_q  <= '0;
      end else begin
         if (can2)                          perf_dual_q   <= perf_dual_q + 32'd1;
         if (can1 && !can2)                 perf_single_q <= perf_single_q + 32'd1;
         if (run && line1_valid_i && !can1) perf_stall_q  <= perf_stall_q + 32'd1;
      end
   end

   assign perf_dual_o   = perf_dual_q;
   assign perf_single_o = perf_single_q;
   assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: directed pairs push expected outputs, a negedge
// monitor pops and compares.
module tb_dual_issue_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       l1_v, l2_v, na, sd, bf, ef;
   logic [4:0] l1_rd, l1_rs1, l1_rs2, l2_rd, l2_rs1, l2_rs2;
   logic       l1_we, l1_u1, l1_u2, l1_ld, l1_br, l1_md, l1_se;
   logic       l2_we, l2_u1, l2_u2, l2_ld, l2_br, l2_md, l2_se;
   logic       qa, ls, i1, i2;
   logic [1:0] st;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic v; logic [4:0] rd; logic we; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
      logic ld; logic br; logic md; logic se;
   } ins_t;

   typedef struct {
      string      name;
      logic [5:0] val;
   } exp_t;

   exp_t exp_q[$];

   // Expected {queue_allowin, lunch_stall, issue1, issue2} patterns.
   localparam logic [3:0] DUAL  = 4'b1011;
   localparam logic [3:0] SOLO  = 4'b1010;
   localparam logic [3:0] SPLIT = 4'b0110;
   localparam logic [3:0] NONE  = 4'b0000;

   dual_issue_ctrl #(
      .REG_AW       (5),
      .FLUSH_BUBBLES(2)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .line1_valid_i    (l1_v),
      .line2_valid_i    (l2_v),
      .next_allowin_i   (na),
      .line1_rd_i       (l1_rd),
      .line1_rd_we_i    (l1_we),
      .line1_rs1_i      (l1_rs1),
      .line1_rs2_i      (l1_rs2),
      .line1_rs1_use_i  (l1_u1),
      .line1_rs2_use_i  (l1_u2),
      .line1_is_load_i  (l1_ld),
      .line1_is_branch_i(l1_br),
      .line1_is_muldiv_i(l1_md),
      .line1_is_serial_i(l1_se),
      .line2_rd_i       (l2_rd),
      .line2_rd_we_i    (l2_we),
      .line2_rs1_i      (l2_rs1),
      .line2_rs2_i      (l2_rs2),
      .line2_rs1_use_i  (l2_u1),
      .line2_rs2_use_i  (l2_u2),
      .line2_is_load_i  (l2_ld),
      .line2_is_branch_i(l2_br),
      .line2_is_muldiv_i(l2_md),
      .line2_is_serial_i(l2_se),
      .serial_done_i    (sd),
      .branch_flush_i   (bf),
      .excep_flush_i    (ef),
      .queue_allowin_o  (qa),
      .lunch_stall_o    (ls),
      .issue1_o         (i1),
      .issue2_o         (i2),
      .state_o          (st)
   );

   always #5 clk = ~clk;

   function automatic ins_t nop();
      ins_t i = '0;
      return i;
   endfunction

   function automatic ins_t alu(int rd, int rs1, int rs2);
      ins_t i = '0;
      i.v = 1'b1; i.rd = 5'(rd); i.we = 1'b1;
      i.rs1 = 5'(rs1); i.u1 = 1'b1; i.rs2 = 5'(rs2); i.u2 = 1'b1;
      return i;
   endfunction

   function automatic ins_t mul(int rd, int rs1, int rs2);
      ins_t i = alu(rd, rs1, rs2);
      i.md = 1'b1;
      return i;
   endfunction

   function automatic ins_t lw(int rd, int rs1);
      ins_t i = alu(rd, rs1, 0);
      i.u2 = 1'b0; i.ld = 1'b1;
      return i;
   endfunction

   function automatic ins_t br(int rs1, int rs2);
      ins_t i = alu(0, rs1, rs2);
      i.we = 1'b0; i.br = 1'b1;
      return i;
   endfunction

   function automatic ins_t csr(int rd, int rs1);
      ins_t i = alu(rd, rs1, 0);
      i.u2 = 1'b0; i.se = 1'b1;
      return i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input ins_t a, input ins_t b, input logic n, input logic s,
                        input logic bfl, input logic efl);
      l1_v = a.v; l1_rd = a.rd; l1_we = a.we; l1_rs1 = a.rs1; l1_u1 = a.u1;
      l1_rs2 = a.rs2; l1_u2 = a.u2; l1_ld = a.ld; l1_br = a.br; l1_md = a.md; l1_se = a.se;
      l2_v = b.v; l2_rd = b.rd; l2_we = b.we; l2_rs1 = b.rs1; l2_u1 = b.u1;
      l2_rs2 = b.rs2; l2_u2 = b.u2; l2_ld = b.ld; l2_br = b.br; l2_md = b.md; l2_se = b.se;
      na = n; sd = s; bf = bfl; ef = efl;
   endtask

   // One cycle of stimulus; expected outputs for that cycle go to the scoreboard.
   task automatic cyc(input string name, input ins_t a, input ins_t b, input logic n,
                      input logic s, input logic bfl, input logic efl,
                      input logic [3:0] o, input logic [1:0] est);
      exp_t e;
      @(posedge clk);
      #1;
      apply(a, b, n, s, bfl, efl);
      e.name = name;
      e.val  = {o, est};
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk(e.name, 32'({qa, ls, i1, i2, st}), 32'(e.val));
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0;
      apply(alu(4, 1, 2), alu(5, 3, 6), 1'b1, 1'b0, 1'b0, 1'b0);
      #3;
      chk("rst_out", 32'({qa, ls, i1, i2}), 32'(NONE));
      chk("rst_state", 32'(st), 32'd0);
      #9 rst_n = 1'b1;

      cyc("indep",    alu(4, 1, 2), alu(5, 3, 6),  1, 0, 0, 0, DUAL,  2'd0);
      cyc("raw",      alu(4, 1, 2), alu(7, 4, 3),  1, 0, 0, 0, SPLIT, 2'd0);
      cyc("raw_next", alu(7, 4, 3), nop(),         1, 0, 0, 0, SOLO,  2'd0);
      cyc("waw",      alu(8, 1, 2), alu(8, 3, 4),  1, 0, 0, 0, SPLIT, 2'd0);
      cyc("rd0",      alu(0, 1, 2), alu(9, 0, 0),  1, 0, 0, 0, DUAL,  2'd0);
      cyc("muldiv",   mul(10, 1, 2), mul(11, 3, 4), 1, 0, 0, 0, SPLIT, 2'd0);
      cyc("mul_alu",  mul(10, 1, 2), alu(11, 3, 4), 1, 0, 0, 0, DUAL,  2'd0);
      cyc("branch",   br(1, 2), alu(12, 3, 4),     1, 0, 0, 0, SPLIT, 2'd0);
      cyc("na0",      alu(4, 1, 2), alu(5, 3, 6),  0, 0, 0, 0, NONE,  2'd0);

      cyc("ld_issue",  lw(7, 1), nop(),            1, 0, 0, 0, SOLO,  2'd0);
      cyc("lu_bub",    alu(8, 7, 2), nop(),        1, 0, 0, 0, NONE,  2'd0);
      cyc("lu_go",     alu(8, 7, 2), nop(),        1, 0, 0, 0, SOLO,  2'd0);
      cyc("ld_issue2", lw(7, 1), nop(),            1, 0, 0, 0, SOLO,  2'd0);
      cyc("lu_hold",   alu(8, 7, 2), nop(),        0, 0, 0, 0, NONE,  2'd0);
      cyc("lu_hold2",  alu(8, 7, 2), nop(),        1, 0, 0, 0, NONE,  2'd0);
      cyc("lu_go2",    alu(8, 7, 2), nop(),        1, 0, 0, 0, SOLO,  2'd0);
      cyc("ld_slot2",  alu(3, 1, 2), lw(12, 1),    1, 0, 0, 0, DUAL,  2'd0);
      cyc("lu_slot2",  alu(13, 12, 2), nop(),      1, 0, 0, 0, NONE,  2'd0);
      cyc("lu_s2_go",  alu(13, 12, 2), nop(),      1, 0, 0, 0, SOLO,  2'd0);
      cyc("ld_issue3", lw(7, 1), nop(),            1, 0, 0, 0, SOLO,  2'd0);
      cyc("lu2",       alu(1, 2, 3), alu(5, 7, 6), 1, 0, 0, 0, SPLIT, 2'd0);
      cyc("lu2_go",    alu(5, 7, 6), nop(),        1, 0, 0, 0, SOLO,  2'd0);

      cyc("csr", csr(4, 5), alu(5, 3, 6), 1, 0, 0, 0, SPLIT, 2'd0);
      for (int k = 0; k < 5; k++)
         cyc("ser_wait", alu(5, 3, 6), alu(6, 1, 2), 1, 0, 0, 0, NONE, 2'd1);
      cyc("ser_done",   alu(5, 3, 6), alu(6, 1, 2), 1, 1, 0, 0, NONE, 2'd1);
      cyc("ser_resume", alu(5, 3, 6), alu(6, 1, 2), 1, 0, 0, 0, DUAL, 2'd0);
      cyc("ser_l2",     alu(1, 2, 3), csr(4, 5),    1, 0, 0, 0, SPLIT, 2'd0);
      cyc("ser_l2_l1",  csr(4, 5), nop(),           1, 0, 0, 0, SOLO,  2'd0);
      cyc("ser_l2_wt",  alu(1, 2, 3), nop(),        1, 1, 0, 0, NONE,  2'd1);
      cyc("ser_l2_go",  alu(1, 2, 3), nop(),        1, 0, 0, 0, SOLO,  2'd0);

      cyc("flush_pair", alu(4, 1, 2), alu(5, 3, 6), 1, 0, 0, 1, NONE, 2'd0);
      cyc("bub1",       alu(4, 1, 2), alu(5, 3, 6), 1, 0, 0, 0, NONE, 2'd2);
      cyc("bub2",       alu(4, 1, 2), alu(5, 3, 6), 1, 0, 0, 0, NONE, 2'd2);
      cyc("flush_run",  alu(4, 1, 2), alu(5, 3, 6), 1, 0, 0, 0, DUAL, 2'd0);
      cyc("csr2",       csr(4, 5), nop(),           1, 0, 0, 0, SOLO, 2'd0);
      cyc("sw_flush",   alu(4, 1, 2), nop(),        1, 1, 0, 1, NONE, 2'd1);
      cyc("sw_bub1",    alu(4, 1, 2), nop(),        1, 0, 0, 0, NONE, 2'd2);
      cyc("sw_bub2",    alu(4, 1, 2), nop(),        1, 0, 0, 0, NONE, 2'd2);
      cyc("sw_run",     alu(4, 1, 2), nop(),        1, 0, 0, 0, SOLO, 2'd0);
      cyc("ld_bf",      lw(7, 1), nop(),            1, 0, 0, 0, SOLO, 2'd0);
      cyc("bf",         alu(8, 7, 2), nop(),        0, 0, 1, 0, NONE, 2'd0);
      cyc("bf_bub1",    alu(8, 7, 2), nop(),        0, 0, 0, 0, NONE, 2'd2);
      cyc("bf_bub2",    alu(8, 7, 2), nop(),        0, 0, 0, 0, NONE, 2'd2);
      cyc("bf_run",     alu(8, 7, 2), nop(),        1, 0, 0, 0, SOLO, 2'd0);

      cyc("csr3", csr(4, 5), nop(),           1, 0, 0, 0, SOLO, 2'd0);
      cyc("sw3",  alu(4, 1, 2), alu(5, 3, 6), 1, 0, 0, 0, NONE, 2'd1);
      @(posedge clk);
      #1;
      apply(alu(4, 1, 2), alu(5, 3, 6), 1'b1, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out", 32'({qa, ls, i1, i2}), 32'(NONE));
      chk("arst_state", 32'(st), 32'd0);
      #3 rst_n = 1'b1;
      cyc("post_rst", alu(8, 7, 2), alu(5, 3, 6), 1, 0, 0, 0, DUAL, 2'd0);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
